// File: rtl/wire_gate_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// wire_gate_sequencer_pkg
// Shared types for the wire-permutation issue controller.
//   gate_instr_t : one gate instruction {c,b,a} at the default wire count.
//   seq_state_t  : program framing states of the sequencer FSM.
// -----------------------------------------------------------------------------
package wire_gate_sequencer_pkg;

  localparam int DEFAULT_WIRES        = 4;
  localparam int DEFAULT_CHOICE_WIDTH = $clog2(DEFAULT_WIRES);

  typedef struct packed {
    logic [DEFAULT_CHOICE_WIDTH-1:0] c;
    logic [DEFAULT_CHOICE_WIDTH-1:0] b;
    logic [DEFAULT_CHOICE_WIDTH-1:0] a;
  } gate_instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  function automatic int pipe_depth(input int gate_latency);
    return 1 + gate_latency;
  endfunction

endpackage

// File: rtl/wire_gate_sequencer_delay_line.sv
// -----------------------------------------------------------------------------
// wire_select_delay_line
// Valid-tagged shift register carrying issued selects down to the output
// stage. An entry written in cycle t appears on o_valid/o_data in t+DEPTH.
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   i_valid      : push an entry this cycle
//   i_data       : entry payload
//   o_valid      : last stage holds a live entry
//   o_data       : last stage payload
//   o_pending    : any live entry in a stage before the last one
// -----------------------------------------------------------------------------
module wire_select_delay_line
  import wire_gate_sequencer_pkg::*;
#(
  parameter type T     = gate_instr_t,
  parameter int  DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_valid,
  input  T     i_data,
  output logic o_valid,
  output T     o_data,
  output logic o_pending
);

  logic [DEPTH-1:0] r_valid;
  T                 r_data [DEPTH];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_data[0]  <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

  // The last stage is retiring this cycle, so it does not count as pending.
  always_comb begin
    o_pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) o_pending = o_pending | r_valid[i];
  end

endmodule

// File: rtl/wire_gate_sequencer.sv
// -----------------------------------------------------------------------------
// wire_gate_sequencer
// Issue controller for the wire-permutation datapath. Drives input-stage
// selects at issue, replays them to the output stage PIPE_DEPTH cycles later,
// stalls reads of wires still in flight and frames a program with start/done.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting instructions until a tlast beat is accepted
// DRAIN | no new issue; waiting for in-flight ops to reach the output
// DONE  | done pulse for one cycle, back to IDLE
//
// Ports:
//   clk, resetn            : clock, synchronous active-low reset
//   start                  : begin a program (IDLE only)
//   instr_tdata/tvalid/... : instruction stream {c,b,a}, a in LSBs
//   in_*_select            : input select stage (live at issue, else held)
//   out_*_select,out_valid : output select stage (held when out_valid=0)
//   busy, done             : state != IDLE, program-retired pulse
//   issued_count           : accepted instructions since last start
// -----------------------------------------------------------------------------
module wire_gate_sequencer
  import wire_gate_sequencer_pkg::*;
#(
  parameter int NUMBER_OF_INPUT_WIRES = DEFAULT_WIRES,
  parameter int CHOICE_WIDTH          = $clog2(NUMBER_OF_INPUT_WIRES),
  parameter int GATE_LATENCY          = 1,
  parameter int COUNT_WIDTH           = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [3*CHOICE_WIDTH-1:0] instr_tdata,
  input  logic                      instr_tvalid,
  input  logic                      instr_tlast,
  output logic                      instr_tready,
  output logic [CHOICE_WIDTH-1:0]   in_a_select,
  output logic [CHOICE_WIDTH-1:0]   in_b_select,
  output logic [CHOICE_WIDTH-1:0]   in_c_select,
  output logic [CHOICE_WIDTH-1:0]   out_a_select,
  output logic [CHOICE_WIDTH-1:0]   out_b_select,
  output logic [CHOICE_WIDTH-1:0]   out_c_select,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      done,
  output logic [COUNT_WIDTH-1:0]    issued_count
);

  localparam int PIPE_DEPTH = pipe_depth(GATE_LATENCY);
  // Scoreboard covers every encodable index; bits for non-existent wires
  // are masked off so out-of-range indices never stall or get tracked.
  localparam int SLOTS = 1 << CHOICE_WIDTH;

  typedef struct packed {
    logic [CHOICE_WIDTH-1:0] c;
    logic [CHOICE_WIDTH-1:0] b;
    logic [CHOICE_WIDTH-1:0] a;
  } instr_t;

  function automatic logic [SLOTS-1:0] wire_bits(input instr_t x);
    logic [SLOTS-1:0] w_mask;
    for (int i = 0; i < SLOTS; i++) w_mask[i] = (i < NUMBER_OF_INPUT_WIRES);
    return w_mask & ((SLOTS'(1) << x.a) | (SLOTS'(1) << x.b) | (SLOTS'(1) << x.c));
  endfunction

  seq_state_t             r_state;
  seq_state_t             w_state_next;
  instr_t                 w_instr;
  instr_t                 r_in_hold;
  instr_t                 r_out_hold;
  instr_t                 w_dl_data;
  logic                   w_dl_valid;
  logic                   w_dl_pending;
  logic [SLOTS-1:0]       r_sb;
  logic [SLOTS-1:0]       w_instr_wires;
  logic [SLOTS-1:0]       w_sb_set;
  logic [SLOTS-1:0]       w_sb_clr;
  logic                   w_hazard;
  logic                   w_issue;
  logic [COUNT_WIDTH-1:0] r_count;

  assign w_instr       = instr_t'(instr_tdata);
  assign w_instr_wires = wire_bits(w_instr);
  assign w_hazard      = |(r_sb & w_instr_wires);
  assign instr_tready  = (r_state == RUN) && !w_hazard;
  assign w_issue       = instr_tvalid && instr_tready;

  assign w_sb_set = w_issue    ? w_instr_wires        : '0;
  assign w_sb_clr = w_dl_valid ? wire_bits(w_dl_data) : '0;

  wire_select_delay_line #(
    .T     (instr_t),
    .DEPTH (PIPE_DEPTH)
  ) u_delay_line (
    .clk       (clk),
    .resetn    (resetn),
    .i_valid   (w_issue),
    .i_data    (w_instr),
    .o_valid   (w_dl_valid),
    .o_data    (w_dl_data),
    .o_pending (w_dl_pending)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_sb       <= '0;
      r_in_hold  <= '0;
      r_out_hold <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_state_next;
      // Set after clear: a wire retiring and re-issued in one cycle stays busy.
      r_sb    <= (r_sb & ~w_sb_clr) | w_sb_set;
      if (w_issue)    r_in_hold  <= w_instr;
      if (w_dl_valid) r_out_hold <= w_dl_data;
      if (r_state == IDLE && start)   r_count <= '0;
      else if (w_issue && ~&r_count)  r_count <= r_count + 1'b1;
    end
  end

  // DRAIN leaves as soon as only the final op (now at the output) remains,
  // so done lands in the cycle right after the last out_valid.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_issue && instr_tlast) w_state_next = DRAIN;
      DRAIN:   if (!w_dl_pending) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign in_a_select  = w_issue ? w_instr.a : r_in_hold.a;
  assign in_b_select  = w_issue ? w_instr.b : r_in_hold.b;
  assign in_c_select  = w_issue ? w_instr.c : r_in_hold.c;

  assign out_valid    = w_dl_valid;
  assign out_a_select = w_dl_valid ? w_dl_data.a : r_out_hold.a;
  assign out_b_select = w_dl_valid ? w_dl_data.b : r_out_hold.b;
  assign out_c_select = w_dl_valid ? w_dl_data.c : r_out_hold.c;

  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  assign issued_count = r_count;

endmodule
